// File: rtl/demux3_8_dispatch.sv
// demux3_8_dispatch: registered write-back dispatcher. Accepts one word plus a
// destination code, loads it into that destination's holding register and
// holds the matching load strobe until the consumer acknowledges (or a wait
// limit expires). Code TRAP_SEL is the reserved constant slot: writes there
// are discarded and raise a sticky trap flag.
module demux3_8_dispatch #(
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 3,
  parameter int TRAP_SEL = 7,
  parameter int TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  reset,     // asynchronous, active-low
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      selector,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out_0,
  output logic [DATA_W-1:0]     data_out_1,
  output logic [DATA_W-1:0]     data_out_2,
  output logic [DATA_W-1:0]     data_out_3,
  output logic [DATA_W-1:0]     data_out_4,
  output logic [DATA_W-1:0]     data_out_5,
  output logic [DATA_W-1:0]     data_out_6,
  output logic [6:0]            load,
  input  logic [6:0]            ack,
  output logic                  trap,
  output logic                  timeout,
  input  logic                  flag_clr
);

  localparam int NUM_DEST = 7;
  // Wait counter width; a zero TIMEOUT still needs a one-bit counter.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SEL_W-1:0] TRAP_CODE = SEL_W'(TRAP_SEL);
  localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_DELIVER = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // load_q doubles as the latched destination: it is one-hot on the active
  // destination for the whole delivery, so no separate selector register.
  logic [NUM_DEST-1:0] load_q, load_d;
  logic                in_ready_q, in_ready_d;
  logic                trap_q, trap_d;
  logic                timeout_q, timeout_d;
  logic [NUM_DEST-1:0] data_we;
  logic [DATA_W-1:0]   data_q [NUM_DEST];

  logic accept;
  logic trap_set;
  logic timeout_set;

  // Next-state logic for the dispatch FSM, wait counter and sticky flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_d      = load_q;
    in_ready_d  = in_ready_q;
    data_we     = '0;
    trap_set    = 1'b0;
    timeout_set = 1'b0;
    accept      = in_valid & in_ready_q;

    case (state_q)
      S_IDLE: begin
        load_d     = '0;
        in_ready_d = 1'b1;
        if (accept) begin
          if (selector == TRAP_CODE) begin
            // Reserved slot: drop the word, stay ready for another accept.
            trap_set = 1'b1;
          end else if (selector < TRAP_CODE) begin
            state_d    = S_DELIVER;
            cnt_d      = '0;
            in_ready_d = 1'b0;
            for (int k = 0; k < NUM_DEST; k++) begin
              if (selector == SEL_W'(k)) begin
                load_d[k]  = 1'b1;
                data_we[k] = 1'b1;
              end
            end
          end
        end
      end

      S_DELIVER: begin
        in_ready_d = 1'b0;
        if ((ack & load_q) != '0) begin
          // Only the ack bit of the active destination counts; it beats
          // the wait limit on the same edge.
          state_d    = S_IDLE;
          load_d     = '0;
          in_ready_d = 1'b1;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          // Give up: the undelivered word stays in its holding register.
          state_d     = S_IDLE;
          load_d      = '0;
          in_ready_d  = 1'b1;
          timeout_set = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        load_d     = '0;
        in_ready_d = 1'b1;
      end
    endcase

    // Set has priority over a simultaneous clear.
    trap_d    = (trap_q & ~flag_clr) | trap_set;
    timeout_d = (timeout_q & ~flag_clr) | timeout_set;
  end

  // FSM state, strobes, ready and flags; in_ready stays low during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      load_q     <= '0;
      in_ready_q <= 1'b0;
      trap_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_q     <= load_d;
      in_ready_q <= in_ready_d;
      trap_q     <= trap_d;
      timeout_q  <= timeout_d;
    end
  end

  // One holding register per destination; written only on its own accept.
  for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_hold
    logic [DATA_W-1:0] data_d;

    // Hold the current word unless this destination was just selected.
    always_comb begin
      data_d = data_q[gi];
      if (data_we[gi]) begin
        data_d = data_in;
      end
    end

    // Holding register, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q[gi] <= '0;
      end else begin
        data_q[gi] <= data_d;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign load       = load_q;
  assign trap       = trap_q;
  assign timeout    = timeout_q;
  assign data_out_0 = data_q[0];
  assign data_out_1 = data_q[1];
  assign data_out_2 = data_q[2];
  assign data_out_3 = data_q[3];
  assign data_out_4 = data_q[4];
  assign data_out_5 = data_q[5];
  assign data_out_6 = data_q[6];

endmodule

// File: tb/tb_demux3_8_dispatch.sv
// Testbench for demux3_8_dispatch: directed scenarios followed by randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_demux3_8_dispatch;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  selector = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic [31:0] data_out_4, data_out_5, data_out_6;
  logic [6:0]  load;
  logic [6:0]  ack = '0;
  logic        trap;
  logic        timeout;
  logic        flag_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state: what each destination holds, whether a delivery
  // is outstanding, to whom, and how many edges it has waited.
  logic [31:0] m_data [7];
  bit          m_busy;
  int          m_dest;
  int          m_waited;
  bit          m_ready;
  bit          m_trap;
  bit          m_to;

  demux3_8_dispatch #(
    .DATA_W(32), .SEL_W(3), .TRAP_SEL(7), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .selector(selector), .data_in(data_in),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .data_out_3(data_out_3), .data_out_4(data_out_4), .data_out_5(data_out_5),
    .data_out_6(data_out_6),
    .load(load), .ack(ack),
    .trap(trap), .timeout(timeout), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_out(input int k);
    case (k)
      0: return data_out_0;
      1: return data_out_1;
      2: return data_out_2;
      3: return data_out_3;
      4: return data_out_4;
      5: return data_out_5;
      default: return data_out_6;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 7; k++) m_data[k] = '0;
    m_busy = 0; m_dest = 0; m_waited = 0;
    m_ready = 0; m_trap = 0; m_to = 0;
  endtask

  // Apply the dispatcher's rules to the inputs present at this rising edge.
  task automatic model_edge();
    bit accept;
    bit set_trap;
    bit set_to;
    accept = in_valid && m_ready;
    set_trap = 0;
    set_to = 0;
    if (m_busy) begin
      if (ack[m_dest]) begin
        m_busy = 0;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_busy = 0;
          set_to = 1;
        end
      end
    end else if (accept) begin
      if (selector == 3'd7) begin
        set_trap = 1;
        $display("accept sel=7 data=%h -> discarded, trap", data_in);
      end else begin
        m_data[selector] = data_in;
        m_dest = int'(selector);
        m_busy = 1;
        m_waited = 0;
        $display("accept sel=%0d data=%h", selector, data_in);
      end
    end
    if (flag_clr) begin
      m_trap = 0;
      m_to = 0;
    end
    if (set_trap) m_trap = 1;
    if (set_to) m_to = 1;
    m_ready = !m_busy;
  endtask

  task automatic check_all();
    logic [6:0] exp_load;
    exp_load = m_busy ? 7'(1 << m_dest) : 7'd0;
    check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    check("load", {25'd0, load}, {25'd0, exp_load});
    check("trap", {31'd0, trap}, {31'd0, m_trap});
    check("timeout", {31'd0, timeout}, {31'd0, m_to});
    for (int k = 0; k < 7; k++) check($sformatf("data_out_%0d", k), dut_out(k), m_data[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic idle_inputs();
    in_valid = 0; ack = '0; flag_clr = 0;
  endtask

  // Assert reset mid-cycle, check the cleared state, release at the falling edge.
  task automatic apply_reset();
    reset = 0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic accept_word(input logic [2:0] sel, input logic [31:0] d);
    in_valid = 1; selector = sel; data_in = d;
    tick();
    in_valid = 0;
  endtask

  initial begin
    model_reset();
    #3;
    apply_reset();
    tick();

    // Delivery to 3 with ack arriving two cycles after the strobe appears.
    accept_word(3'd3, 32'hDEADBEEF);
    tick(); tick();
    ack = 7'b0001000;
    tick();
    ack = '0;
    tick();

    // Reserved slot, then clear together with a second reserved write.
    accept_word(3'd7, 32'h12345678);
    in_valid = 1; selector = 3'd7; flag_clr = 1;
    tick();
    idle_inputs();
    tick();

    // Clear flags, then a delivery nobody acknowledges.
    flag_clr = 1; tick(); flag_clr = 0;
    accept_word(3'd0, $urandom);
    repeat (TIMEOUT + 2) tick();

    // Foreign ack bits are ignored, then the real ack completes.
    flag_clr = 1; tick(); flag_clr = 0;
    accept_word(3'd5, $urandom);
    ack = 7'b1000100; tick(); tick();
    ack = '0; tick();
    ack = 7'b0100000; tick();
    ack = '0; tick();

    // Reset in the middle of a delivery, then a normal delivery.
    accept_word(3'd1, 32'hA5A5A5A5);
    tick();
    apply_reset();
    tick();
    in_valid = 1; selector = 3'd1; data_in = 32'h1; ack = 7'b0000010;
    tick();
    in_valid = 0;
    tick();
    ack = '0;
    tick();

    // Stream every destination with ack tied high.
    ack = 7'h7F;
    in_valid = 1;
    for (int k = 0; k < 7; k++) begin
      selector = 3'(k);
      data_in = $urandom;
      tick();
      tick();
    end
    idle_inputs();
    tick();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      selector = 3'($urandom_range(0, 7));
      data_in = $urandom;
      for (int b = 0; b < 7; b++) ack[b] = ($urandom_range(0, 4) == 0);
      flag_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        apply_reset();
      end
      tick();
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
